// File: rtl/vector_wb_arbiter.sv
// Vector register file writeback arbiter: per-source FIFOs feeding one registered
// write port through a round-robin grant, with per-element write masks.
module vector_wb_arbiter #(
  parameter int unsigned NUM_SRC      = 3,
  parameter int unsigned NUM_ELEMENTS = 32,
  parameter int unsigned ELEM_W       = 16,
  parameter int unsigned VREG_ADDR_W  = 6,
  parameter int unsigned DEPTH        = 4
) (
  input  logic                                  CLK,
  input  logic                                  RST,
  input  logic [NUM_SRC-1:0]                    src_valid,
  output logic [NUM_SRC-1:0]                    src_ready,
  input  logic [NUM_SRC*VREG_ADDR_W-1:0]        src_vd,
  input  logic [NUM_SRC*NUM_ELEMENTS*ELEM_W-1:0] src_data,
  input  logic [NUM_SRC*NUM_ELEMENTS-1:0]       src_mask,
  input  logic                                  wb_stall,
  output logic                                  wb_wen,
  output logic [VREG_ADDR_W-1:0]                wb_vd,
  output logic [NUM_ELEMENTS*ELEM_W-1:0]        wb_data,
  output logic [NUM_ELEMENTS-1:0]               wb_mask,
  output logic [((NUM_SRC > 1) ? $clog2(NUM_SRC) : 1)-1:0] wb_src,
  output logic                                  busy
);

  localparam int unsigned SRC_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int unsigned DATA_W = NUM_ELEMENTS * ELEM_W;
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [VREG_ADDR_W-1:0]  vd;
    logic [DATA_W-1:0]       data;
    logic [NUM_ELEMENTS-1:0] mask;
  } wb_entry_t;

  localparam int unsigned ENTRY_W = $bits(wb_entry_t);

  logic [NUM_SRC-1:0]         push;
  logic [NUM_SRC-1:0]         pop;
  logic [NUM_SRC-1:0]         nonempty;
  logic [NUM_SRC*ENTRY_W-1:0] heads;
  logic                       grant;
  logic [SRC_W-1:0]           winner;
  logic [SRC_W-1:0]           cand;
  logic [SRC_W-1:0]           rr_ptr;
  logic [SRC_W-1:0]           rr_next;
  wb_entry_t                  head;

  // One circular FIFO per source; ready depends only on registered count.
  for (genvar g = 0; g < NUM_SRC; g++) begin : g_fifo
    wb_entry_t        mem [DEPTH];
    wb_entry_t        entry_in;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    assign entry_in = '{vd:   src_vd[g*VREG_ADDR_W +: VREG_ADDR_W],
                        data: src_data[g*DATA_W +: DATA_W],
                        mask: src_mask[g*NUM_ELEMENTS +: NUM_ELEMENTS]};

    assign src_ready[g] = (count < CNT_W'(DEPTH));
    assign push[g]      = src_valid[g] & src_ready[g];
    assign nonempty[g]  = (count != '0);
    assign heads[g*ENTRY_W +: ENTRY_W] = mem[rd_ptr];

    always_ff @(posedge CLK) begin
      if (RST) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push[g]) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop[g])  rd_ptr <= rd_ptr + PTR_W'(1);
        if (push[g] && !pop[g])      count <= count + CNT_W'(1);
        else if (!push[g] && pop[g]) count <= count - CNT_W'(1);
      end
    end

    always_ff @(posedge CLK) begin
      if (!RST && push[g]) mem[wr_ptr] <= entry_in;
    end
  end

  // Round-robin scan starting at rr_ptr; a stalled register file blocks any grant.
  always_comb begin
    grant  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      cand = SRC_W'((32'(rr_ptr) + k) % NUM_SRC);
      if (!wb_stall && !grant && nonempty[cand]) begin
        grant  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    pop = '0;
    if (grant) pop[winner] = 1'b1;
  end

  assign head    = heads[32'(winner)*ENTRY_W +: ENTRY_W];
  assign rr_next = (winner == SRC_W'(NUM_SRC - 1)) ? '0 : winner + SRC_W'(1);

  // Registered write port; an all-zero mask consumes the entry without writing.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rr_ptr  <= '0;
      wb_wen  <= 1'b0;
      wb_vd   <= '0;
      wb_data <= '0;
      wb_mask <= '0;
      wb_src  <= '0;
    end else begin
      wb_wen <= grant && (|head.mask);
      if (grant) begin
        rr_ptr  <= rr_next;
        wb_vd   <= head.vd;
        wb_data <= head.data;
        wb_mask <= head.mask;
        wb_src  <= winner;
      end
    end
  end

  assign busy = wb_wen | (|nonempty);

endmodule

// File: tb/tb_vector_wb_arbiter.sv
// Scoreboard bench for vector_wb_arbiter: expected writes queued per source at
// drive time, popped and compared whenever the write port fires.
module tb_vector_wb_arbiter;

  localparam int unsigned NS = 3;
  localparam int unsigned NE = 32;
  localparam int unsigned EW = 16;
  localparam int unsigned VW = 6;
  localparam int unsigned DW = NE * EW;

  typedef struct packed {
    logic [VW-1:0] vd;
    logic [DW-1:0] data;
    logic [NE-1:0] mask;
  } exp_t;

  logic             CLK;
  logic             RST;
  logic [NS-1:0]    src_valid;
  logic [NS-1:0]    src_ready;
  logic [NS*VW-1:0] src_vd;
  logic [NS*DW-1:0] src_data;
  logic [NS*NE-1:0] src_mask;
  logic             wb_stall;
  logic             wb_wen;
  logic [VW-1:0]    wb_vd;
  logic [DW-1:0]    wb_data;
  logic [NE-1:0]    wb_mask;
  logic [1:0]       wb_src;
  logic             busy;

  vector_wb_arbiter #(
    .NUM_SRC(NS), .NUM_ELEMENTS(NE), .ELEM_W(EW), .VREG_ADDR_W(VW), .DEPTH(4)
  ) dut (
    .CLK(CLK), .RST(RST),
    .src_valid(src_valid), .src_ready(src_ready),
    .src_vd(src_vd), .src_data(src_data), .src_mask(src_mask),
    .wb_stall(wb_stall), .wb_wen(wb_wen), .wb_vd(wb_vd),
    .wb_data(wb_data), .wb_mask(wb_mask), .wb_src(wb_src), .busy(busy)
  );

  int   n_checks = 0;
  int   n_pass = 0;
  int   writes_seen = 0;
  bit   rr_capture = 0;
  int   rr_seq[$];
  exp_t sb_q[NS][$];

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, got running required finished");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int k = 0; k < DW / 32; k++) d[k*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic drive(input int s, input logic [VW-1:0] vd, input logic [DW-1:0] data,
                       input logic [NE-1:0] mask, input bit accept);
    exp_t e;
    src_valid[s] = 1'b1;
    src_vd[s*VW +: VW] = vd;
    src_data[s*DW +: DW] = data;
    src_mask[s*NE +: NE] = mask;
    e.vd = vd;
    e.data = data;
    e.mask = mask;
    if (accept && mask != '0) sb_q[s].push_back(e);
  endtask

  task automatic idle();
    src_valid = '0;
  endtask

  task automatic flush_sb();
    for (int s = 0; s < NS; s++) sb_q[s].delete();
  endtask

  task automatic do_reset();
    RST = 1'b1;
    flush_sb();
    step();
    RST = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    bit done = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge CLK);
      done = (busy === 1'b0) && sb_q[0].size() == 0 && sb_q[1].size() == 0 && sb_q[2].size() == 0;
    end
    check(tag, DW'(done), DW'(1));
  endtask

  // Write-port monitor: every write must match the oldest pending entry of its source.
  always @(negedge CLK) begin
    if (!RST && wb_wen === 1'b1) begin
      bit   have;
      exp_t e;
      writes_seen++;
      if (rr_capture) rr_seq.push_back(int'(wb_src));
      have = 0;
      if (wb_src < 2'(NS)) have = sb_q[wb_src].size() != 0;
      check("wb_expected", DW'(have), DW'(1));
      if (have) begin
        e = sb_q[wb_src].pop_front();
        check("wb_vd", DW'(wb_vd), DW'(e.vd));
        check("wb_data", wb_data, e.data);
        check("wb_mask", DW'(wb_mask), DW'(e.mask));
      end
    end
  end

  initial begin
    int w0;
    logic [DW-1:0] d;
    RST = 1'b1;
    src_valid = '0;
    src_vd = '0;
    src_data = '0;
    src_mask = '0;
    wb_stall = 1'b0;
    step();
    step();
    RST = 1'b0;
    @(negedge CLK);
    check("rst_wen", DW'(wb_wen), DW'(0));
    check("rst_busy", DW'(busy), DW'(0));
    check("rst_ready", DW'(src_ready), DW'(3'b111));
    check("rst_vd", DW'(wb_vd), DW'(0));
    check("rst_src", DW'(wb_src), DW'(0));

    // Reset mid-operation discards buffered entries
    wb_stall = 1'b1;
    drive(0, 6'd1, rand_data(), '1, 1);
    step();
    drive(0, 6'd2, rand_data(), '1, 1);
    step();
    idle();
    @(negedge CLK);
    check("prerst_busy", DW'(busy), DW'(1));
    RST = 1'b1;
    flush_sb();
    step();
    RST = 1'b0;
    @(negedge CLK);
    check("midrst_wen", DW'(wb_wen), DW'(0));
    check("midrst_busy", DW'(busy), DW'(0));
    check("midrst_ready", DW'(src_ready), DW'(3'b111));
    wb_stall = 1'b0;
    step();
    @(negedge CLK);
    check("postrst_wen", DW'(wb_wen), DW'(0));
    check("postrst_busy", DW'(busy), DW'(0));

    // Single-source latency
    d = rand_data();
    d[15:0] = 16'h3C00;
    drive(1, 6'd5, d, '1, 1);
    step();
    idle();
    @(negedge CLK);
    check("lat_t1_wen", DW'(wb_wen), DW'(0));
    check("lat_t1_busy", DW'(busy), DW'(1));
    step();
    @(negedge CLK);
    check("lat_t2_wen", DW'(wb_wen), DW'(1));
    check("lat_t2_vd", DW'(wb_vd), DW'(5));
    check("lat_t2_src", DW'(wb_src), DW'(1));
    check("lat_t2_elem0", DW'(wb_data[15:0]), DW'(16'h3C00));
    step();
    @(negedge CLK);
    check("lat_t3_wen", DW'(wb_wen), DW'(0));
    check("lat_t3_busy", DW'(busy), DW'(0));

    // Round robin across all sources
    do_reset();
    rr_capture = 1;
    for (int c = 0; c < 4; c++) begin
      for (int s = 0; s < NS; s++) drive(s, 6'(s * 16 + c), rand_data(), 32'($urandom) | 32'h1, 1);
      step();
    end
    idle();
    wait_drain("rr_drain");
    rr_capture = 0;
    check("rr_count", DW'(rr_seq.size()), DW'(12));
    for (int k = 0; k < rr_seq.size() && k < 12; k++)
      check($sformatf("rr_order_%0d", k), DW'(rr_seq[k]), DW'(k % 3));

    // Full FIFO backpressure under stall
    do_reset();
    wb_stall = 1'b1;
    for (int c = 0; c < 4; c++) begin
      drive(2, 6'(20 + c), rand_data(), '1, 1);
      step();
    end
    idle();
    @(negedge CLK);
    check("full_ready", DW'(src_ready), DW'(3'b011));
    check("full_busy", DW'(busy), DW'(1));
    drive(2, 6'd59, rand_data(), '1, 0);
    step();
    idle();
    @(negedge CLK);
    check("full_ready_hold", DW'(src_ready), DW'(3'b011));
    check("full_stall_wen", DW'(wb_wen), DW'(0));
    wb_stall = 1'b0;
    w0 = writes_seen;
    step();
    @(negedge CLK);
    check("full_ready_back", DW'(src_ready), DW'(3'b111));
    check("full_first_wen", DW'(wb_wen), DW'(1));
    check("full_first_vd", DW'(wb_vd), DW'(20));
    wait_drain("full_drain");
    check("full_writes", DW'(writes_seen - w0), DW'(4));

    // Streaming single source: simultaneous push and pop each cycle
    do_reset();
    for (int c = 0; c < 8; c++) begin
      drive(0, 6'(32 + c), rand_data(), '1, 1);
      step();
      @(negedge CLK);
      if (c > 0) begin
        check($sformatf("stream_wen_%0d", c), DW'(wb_wen), DW'(1));
        check($sformatf("stream_ready_%0d", c), DW'(src_ready[0]), DW'(1));
      end
    end
    idle();
    step();
    @(negedge CLK);
    check("stream_last_wen", DW'(wb_wen), DW'(1));
    step();
    @(negedge CLK);
    check("stream_end_wen", DW'(wb_wen), DW'(0));
    wait_drain("stream_drain");

    // Zero-mask entry is consumed without a write
    do_reset();
    w0 = writes_seen;
    drive(0, 6'd7, rand_data(), '0, 1);
    step();
    drive(0, 6'd8, rand_data(), '1, 1);
    step();
    idle();
    @(negedge CLK);
    check("zm_wen", DW'(wb_wen), DW'(0));
    check("zm_vd", DW'(wb_vd), DW'(7));
    check("zm_src", DW'(wb_src), DW'(0));
    step();
    @(negedge CLK);
    check("zm_next_wen", DW'(wb_wen), DW'(1));
    check("zm_next_vd", DW'(wb_vd), DW'(8));
    wait_drain("zm_drain");
    check("zm_writes", DW'(writes_seen - w0), DW'(1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vector_wb_arbiter.md
Name: vector_wb_arbiter

Overview:
- Writeback stage directly upstream of the vector register file (veggie) write port.
- Accepts result vectors from NUM_SRC functional units (VALU lanes, mask unit, ...), buffers each source in its own FIFO, and round-robin arbitrates them onto the single registered veggie write port.
- Preserves per-source write order and supports per-element write masks.
- Applies backpressure per source and honours a write-port stall from the register file.

Parameters:
- NUM_SRC, 3: number of producing functional units.
- NUM_ELEMENTS, 32: elements per vector register.
- ELEM_W, 16: bits per element (FP16).
- VREG_ADDR_W, 6: vector destination register index width.
- DEPTH, 4: entries per source FIFO; power of two, at least 2.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  synchronous, active-high reset.
- src_valid  input  NUM_SRC  per-source result valid.
- src_ready  output  NUM_SRC  per-source FIFO can accept.
- src_vd  input  NUM_SRC*VREG_ADDR_W  per-source destination register; source i occupies slice i.
- src_data  input  NUM_SRC*NUM_ELEMENTS*ELEM_W  per-source result vector.
- src_mask  input  NUM_SRC*NUM_ELEMENTS  per-source element write mask.
- wb_stall  input  1  register file cannot take a write this cycle.
- wb_wen  output  1  register file write enable.
- wb_vd  output  VREG_ADDR_W  write destination.
- wb_data  output  NUM_ELEMENTS*ELEM_W  write data.
- wb_mask  output  NUM_ELEMENTS*ELEM_W/ELEM_W (NUM_ELEMENTS)  per-element write enable.
- wb_src  output  $clog2(NUM_SRC)  source index of the current write, for scoreboard release.
- busy  output  1  any FIFO is non-empty or wb_wen is high.

Behaviour:
- Reset (RST high at an edge):
  - All FIFO counts, read pointers and write pointers go to 0.
  - Round-robin pointer goes to 0.
  - wb_wen, wb_vd, wb_data, wb_mask and wb_src go to 0.
  - Reset mid-operation discards all buffered entries. No write is issued in the cycle after reset.
- Handshake:
  - src_ready[i] = (count[i] < DEPTH). It is combinational from registered state only; there is no same-cycle pop bypass.
  - A push happens when src_valid[i] && src_ready[i].
  - A full FIFO deasserts ready even if it is being popped this cycle.
- FIFO:
  - Circular buffer; pointers wrap from DEPTH-1 to 0.
  - Push and pop on the same FIFO in the same cycle: both take effect and the count is unchanged.
- Arbitration (combinational, evaluated each cycle):
  - Candidates are the non-empty FIFOs.
  - If wb_stall is high, there is no grant.
  - Otherwise the winner is the first non-empty source found scanning from rr_ptr upward, modulo NUM_SRC.
  - On a grant, the winner's head is popped and rr_ptr becomes (winner+1) mod NUM_SRC.
  - With no grant, rr_ptr holds.
- Output register:
  - On a grant, the next cycle has wb_wen = 1 and wb_vd/wb_data/wb_mask/wb_src equal to the popped head.
  - Without a grant, wb_wen = 0 next cycle; the data outputs hold their last value.
- Zero-mask entries: an entry whose mask is all zeros is popped when granted, but wb_wen stays 0. wb_src is still updated.
- Latency:
  - Push accepted at edge t; entry is at the FIFO head from t.
  - It can be granted in cycle t+1 at the earliest.
  - wb_wen rises after edge t+1, giving 2-cycle minimum latency.
  - Throughput is one write per cycle.
- Ordering:
  - Within a source, order is strictly FIFO.
  - There is no ordering guarantee across sources; the scoreboard upstream prevents cross-source WAW on the same vd.
- wb_stall timing: sampled only for the grant decision. A write already presented on wb_wen is never replayed.

Test Plan:
- Reset: push 2 entries into src0, assert RST for 1 cycle -> next cycles wb_wen=0, busy=0, src_ready=3'b111.
- Single source latency: src1 pushes vd=5, data element0=16'h3C00, mask=all-ones at edge t -> wb_wen=1 at t+2 with wb_vd=5, wb_src=1; busy drops the cycle after.
- Round robin: all three sources push every cycle for 4 cycles -> wb_src sequence 0,1,2,0,1,2,...; 12 writes total; per-source vd order preserved.
- Full/backpressure: src2 pushes 4 entries with wb_stall=1 -> src_ready[2]=0 after the 4th; a 5th src_valid is not accepted. Release stall -> 4 writes in order, and ready returns the cycle after the first pop.
- Simultaneous push/pop: src0 streams one entry per cycle with wb_stall=0 and only src0 active -> count stays at 1, wb_wen stays high every cycle from cycle 2.
- Zero mask: src0 pushes vd=7 with mask=0, then vd=8 with mask=all-ones -> no write for vd=7; one write for vd=8 with wb_wen=1.
